counter: RTL and testbench

- Parameterised synchronous modulo counter, used as the digit building block of the clock datapath (seconds, minutes, hours digits).
- Counts up on each enabled clock edge from 0 to a programmable terminal value, then wraps to 0.
- Emits a one-cycle registered carry pulse on wrap, which cascades into the next digit's i_Enable_Count.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter.sv | 61 ++++++
 tb/tb_counter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the clock-datapath digit counter: the per-edge update
// operation and the helper that selects it from enable and terminal state.
package counter_pkg;

  // What the count register does on the next rising edge (outside reset).
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_WRAP = 2'd2
  } cnt_op_e;

  // Enable gates everything; at the terminal value an enabled edge wraps,
  // otherwise it increments. Out-of-range values simply increment, so they
  // roll over at 2^width without producing a carry.
  function automatic cnt_op_e f_select_op(input logic i_en, input logic i_at_term);
    if (!i_en) begin
      return OP_HOLD;
    end else if (i_at_term) begin
      return OP_WRAP;
    end else begin
      return OP_INC;
    end
  endfunction

endpackage

// File: rtl/counter.sv
// Modulo-N digit counter for the clock datapath. Counts 0..c_RESET_VALUE on
// enabled edges, wraps to 0 and raises a one-cycle registered carry that is
// coincident with the wrapped zero. o_Carry feeds the next digit's enable.
module counter
  import counter_pkg::*;
#(
  parameter int                 c_WIDTH       = 4,
  parameter logic [c_WIDTH-1:0] c_RESET_VALUE = {c_WIDTH{1'b1}}
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Enable_Count,
  output logic [c_WIDTH-1:0] o_Data,
  output logic               o_Carry
);

  logic [c_WIDTH-1:0] r_Data;
  logic               r_Carry;
  logic               w_At_Terminal;
  cnt_op_e            w_Op;
  logic [c_WIDTH-1:0] w_Next_Data;
  logic               w_Next_Carry;

  // Exact compare: values above the terminal never match and roll over naturally.
  assign w_At_Terminal = (r_Data == c_RESET_VALUE);

  // Next-state selection: hold, increment, or wrap-with-carry.
  always_comb begin
    w_Op         = f_select_op(i_Enable_Count, w_At_Terminal);
    w_Next_Data  = r_Data;
    w_Next_Carry = 1'b0;
    case (w_Op)
      OP_INC: begin
        w_Next_Data = r_Data + c_WIDTH'(1);
      end
      OP_WRAP: begin
        w_Next_Data  = '0;
        w_Next_Carry = 1'b1;
      end
      default: begin
        w_Next_Data  = r_Data;
        w_Next_Carry = 1'b0;
      end
    endcase
  end

  // Registered count and carry; reset clears both and takes priority over enable.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Data  <= '0;
      r_Carry <= 1'b0;
    end else begin
      r_Data  <= w_Next_Data;
      r_Carry <= w_Next_Carry;
    end
  end

  assign o_Data  = r_Data;
  assign o_Carry = r_Carry;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for the digit counter: one instance with the default
// terminal (15) and one with terminal 9. Stimulus pushes hand-computed
// expected outputs; a monitor pops and compares on every falling edge.
module tb_counter;

  typedef struct {
    logic [3:0] d;
    logic       c;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_a, en_a, rst_b, en_b;
  logic [3:0] data_a, data_b;
  logic       carry_a, carry_b;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_errors = 0;

  counter u_dut_a (
    .i_Clock        (clk),
    .i_Reset        (rst_a),
    .i_Enable_Count (en_a),
    .o_Data         (data_a),
    .o_Carry        (carry_a)
  );

  counter #(
    .c_WIDTH       (4),
    .c_RESET_VALUE (4'd9)
  ) u_dut_b (
    .i_Clock        (clk),
    .i_Reset        (rst_b),
    .i_Enable_Count (en_b),
    .o_Data         (data_b),
    .o_Carry        (carry_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, let one rising edge pass, record what must appear after it.
  task automatic step_a(input logic r, input logic e, input int d, input logic c, input string tag);
    exp_t x;
    rst_a = r;
    en_a  = e;
    @(posedge clk);
    x.d = 4'(d);
    x.c = c;
    x.tag = tag;
    q_a.push_back(x);
    #1;
  endtask

  task automatic step_b(input logic r, input logic e, input int d, input logic c, input string tag);
    exp_t x;
    rst_b = r;
    en_b  = e;
    @(posedge clk);
    x.d = 4'(d);
    x.c = c;
    x.tag = tag;
    q_b.push_back(x);
    #1;
  endtask

  // Monitor: outputs are registered, so every falling edge presents a result.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_t x;
      x = q_a.pop_front();
      n_checks++;
      if (data_a !== x.d || carry_a !== x.c) begin
        n_errors++;
        $display("FAIL t15 %s: got data=%0d carry=%0b, expected data=%0d carry=%0b",
                 x.tag, data_a, carry_a, x.d, x.c);
      end
    end
    if (q_b.size() > 0) begin
      exp_t x;
      x = q_b.pop_front();
      n_checks++;
      if (data_b !== x.d || carry_b !== x.c) begin
        n_errors++;
        $display("FAIL t9 %s: got data=%0d carry=%0b, expected data=%0d carry=%0b",
                 x.tag, data_b, carry_b, x.d, x.c);
      end
    end
  end

  initial begin
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    #2;

    // Reset then release with enable low.
    step_a(1, 0, 0, 0, "reset");
    step_a(0, 0, 0, 0, "idle_after_reset");

    // Basic count to terminal, wrap with carry, then one more.
    for (int i = 1; i <= 15; i++) step_a(0, 1, i, 0, "count");
    step_a(0, 1, 0, 1, "wrap16");
    step_a(0, 1, 1, 0, "edge17");

    // Count to next wrap, then disable for 5 edges.
    for (int i = 2; i <= 15; i++) step_a(0, 1, i, 0, "count2");
    step_a(0, 1, 0, 1, "wrap2");
    for (int i = 0; i < 5; i++) step_a(0, 0, 0, 0, "disabled_after_wrap");

    // Three full periods: one carry per 16 edges, on the zero.
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 15; i++) step_a(0, 1, i, 0, "period_count");
      step_a(0, 1, 0, 1, "period_wrap");
    end

    // Reset mid-count (enable held high: reset wins), then toggle 1/0/1.
    step_a(0, 1, 1, 0, "pre_mid");
    step_a(0, 1, 2, 0, "at_two");
    step_a(1, 1, 0, 0, "mid_reset");
    step_a(0, 1, 1, 0, "toggle_hi1");
    step_a(0, 0, 1, 0, "toggle_lo");
    step_a(0, 1, 2, 0, "toggle_hi2");

    // Reset while the carry is high clears it.
    for (int i = 3; i <= 15; i++) step_a(0, 1, i, 0, "count3");
    step_a(0, 1, 0, 1, "wrap3");
    step_a(1, 0, 0, 0, "reset_clears_carry");

    // Reset at terminal with enable high: no wrap carry.
    for (int i = 1; i <= 15; i++) step_a(0, 1, i, 0, "count4");
    step_a(1, 1, 0, 0, "reset_at_terminal");
    step_a(0, 1, 1, 0, "resume");

    // Terminal 9: 0..9 then 0 with carry, twice; 10 never appears.
    step_b(1, 0, 0, 0, "reset");
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 9; i++) step_b(0, 1, i, 0, "count");
      step_b(0, 1, 0, 1, "wrap10");
    end
    step_b(0, 1, 1, 0, "after_wrap");

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending t15=%0d t9=%0d, expected 0 and 0", q_a.size(), q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
